// File: rtl/bus_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, status bit
// positions and the serial state machine encodings.
package bus_uart_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_DIVL = 2'd2;
    localparam logic [1:0] REG_DIVH = 2'd3;

    localparam int ST_TXFULL  = 0;
    localparam int ST_TXEMPTY = 1;
    localparam int ST_RXVALID = 2;
    localparam int ST_OVERRUN = 3;
    localparam int ST_TXBUSY  = 4;
    localparam int ST_FRERR   = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/bus_uart_fifo.sv
// Small first-word-fall-through byte queue used for the UART transmit path.
// A push while full is only taken when a pop frees the slot on the same edge.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bus_uart.sv
// 8N1 UART slave on the CPU byte bus: TX FIFO, single-byte RX holding register
// and a programmable baud divisor (bit period = div + 1 clocks).
module bus_uart
    import bus_uart_pkg::*;
#(
    parameter logic [15:0] BASE    = 16'h0110,
    parameter int          TXDEPTH = 4,
    parameter logic [15:0] DIV_RST = 16'd15
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        valid,
    input  logic        write,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        sel,
    output logic        txd,
    input  logic        rxd
);

    logic [15:0] offset_full;
    logic [1:0]  offset;
    logic        fire;
    logic        wr_data;
    logic        rd_data;
    logic        wr_stat;
    logic [15:0] div;
    logic [7:0]  status;

    logic        tx_full;
    logic        tx_empty;
    logic        tx_pop;
    logic [7:0]  fifo_dout;
    tx_state_t   tx_state;
    tx_state_t   tx_next;
    logic [15:0] tx_cnt;
    logic [15:0] tx_cnt_next;
    logic [7:0]  tx_shift;
    logic [7:0]  tx_shift_next;
    logic [2:0]  tx_bit;
    logic [2:0]  tx_bit_next;
    logic        tx_tick;

    logic        rx_s1;
    logic        rx_s2;
    logic        rx_prev;
    rx_state_t   rx_state;
    rx_state_t   rx_next;
    logic [15:0] rx_cnt;
    logic [15:0] rx_cnt_next;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_shift_next;
    logic [2:0]  rx_bit;
    logic [2:0]  rx_bit_next;
    logic        rx_tick;
    logic        rx_done;
    logic        rx_ferr;
    logic [7:0]  rx_hold;
    logic        rx_valid;
    logic        overrun;
    logic        frame_err;

    // Subtracting BASE makes the window check immune to address wrap-around.
    assign offset_full = addr - BASE;
    assign sel         = (offset_full < 16'd4);
    assign offset      = offset_full[1:0];
    assign fire        = valid & sel & ~ready;
    assign wr_data     = fire & write & (offset == REG_DATA);
    assign rd_data     = fire & ~write & (offset == REG_DATA);
    assign wr_stat     = fire & write & (offset == REG_STAT);

    always_comb begin
        status              = '0;
        status[ST_TXFULL]   = tx_full;
        status[ST_TXEMPTY]  = tx_empty;
        status[ST_RXVALID]  = rx_valid;
        status[ST_OVERRUN]  = overrun;
        status[ST_TXBUSY]   = (tx_state != TX_IDLE) | ~tx_empty;
        status[ST_FRERR]    = frame_err;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ready <= 1'b0;
            rdata <= 8'h00;
            div   <= DIV_RST;
        end else begin
            if (fire)        ready <= 1'b1;
            else if (!valid) ready <= 1'b0;
            if (fire && !write) begin
                case (offset)
                    REG_DATA: rdata <= rx_valid ? rx_hold : 8'h00;
                    REG_STAT: rdata <= status;
                    REG_DIVL: rdata <= div[7:0];
                    default:  rdata <= div[15:8];
                endcase
            end
            if (fire && write && offset == REG_DIVL) div[7:0]  <= wdata;
            if (fire && write && offset == REG_DIVH) div[15:8] <= wdata;
        end
    end

    byte_fifo #(.DEPTH(TXDEPTH)) u_txfifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (wr_data),
        .pop   (tx_pop),
        .wdata (wdata),
        .rdata (fifo_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_next;
            tx_shift <= tx_shift_next;
            tx_bit   <= tx_bit_next;
        end
    end

    // Every bit boundary reloads from div, so divisor writes apply at the next bit.
    always_comb begin
        tx_next       = tx_state;
        tx_tick       = (tx_cnt == 16'd0);
        tx_cnt_next   = tx_tick ? div : tx_cnt - 16'd1;
        tx_shift_next = tx_shift;
        tx_bit_next   = tx_bit;
        tx_pop        = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_cnt_next = div;
                if (!tx_empty) begin
                    tx_next       = TX_START;
                    tx_pop        = 1'b1;
                    tx_shift_next = fifo_dout;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_next     = TX_DATA;
                    tx_bit_next = 3'd0;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit == 3'd7) begin
                        tx_next = TX_STOP;
                    end else begin
                        tx_shift_next = {1'b0, tx_shift[7:1]};
                        tx_bit_next   = tx_bit + 3'd1;
                    end
                end
            end
            default: begin
                if (tx_tick) begin
                    if (!tx_empty) begin
                        tx_next       = TX_START;
                        tx_pop        = 1'b1;
                        tx_shift_next = fifo_dout;
                    end else begin
                        tx_next = TX_IDLE;
                    end
                end
            end
        endcase
    end

    assign txd = (tx_state == TX_START) ? 1'b0 :
                 (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_next;
            rx_shift <= rx_shift_next;
            rx_bit   <= rx_bit_next;
        end
    end

    // Start-bit check lands mid-bit; every later sample is one bit period on.
    always_comb begin
        rx_next       = rx_state;
        rx_tick       = (rx_cnt == 16'd0);
        rx_cnt_next   = rx_tick ? div : rx_cnt - 16'd1;
        rx_shift_next = rx_shift;
        rx_bit_next   = rx_bit;
        rx_done       = 1'b0;
        rx_ferr       = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_next = {1'b0, div[15:1]};
                if (rx_prev && !rx_s2) rx_next = RX_START;
            end
            RX_START: begin
                if (rx_tick) begin
                    if (rx_s2) begin
                        rx_next = RX_IDLE;
                    end else begin
                        rx_next     = RX_DATA;
                        rx_bit_next = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_next = {rx_s2, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_next = RX_STOP;
                    else                rx_bit_next = rx_bit + 3'd1;
                end
            end
            default: begin
                if (rx_tick) begin
                    rx_next = RX_IDLE;
                    rx_done = rx_s2;
                    rx_ferr = ~rx_s2;
                end
            end
        endcase
    end

    // A DATA read on the completion edge frees the holding register in time.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_hold   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if ((wr_data && tx_full && !tx_pop) || (rx_done && rx_valid && !rd_data))
                overrun <= 1'b1;
            else if (wr_stat && wdata[ST_OVERRUN])
                overrun <= 1'b0;
            if (rx_ferr)
                frame_err <= 1'b1;
            else if (wr_stat && wdata[ST_FRERR])
                frame_err <= 1'b0;
            if (rx_done && (!rx_valid || rd_data)) begin
                rx_hold  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_uart.sv
// Self-checking bench for bus_uart: register vectors from a table, a read-data
// scoreboard, a serial-bit scoreboard for txd, and RX/reset corner sequences.
module tb_bus_uart;
    import bus_uart_pkg::*;

    localparam logic [15:0] BASE = 16'h0110;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        valid = 1'b0;
    logic        write = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic [7:0]  rdata;
    logic        ready;
    logic        sel;
    logic        txd;
    logic        rxd = 1'b1;

    int vec_count = 0;
    int miss_count = 0;
    logic [7:0] exp_q[$];
    logic       tx_q[$];

    typedef struct {
        logic       wr;
        logic [1:0] off;
        logic [7:0] wd;
        logic [7:0] expect_rd;
    } vec_t;

    vec_t vecs[11];

    bus_uart #(.BASE(BASE), .TXDEPTH(4), .DIV_RST(16'd15)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .valid (valid),
        .write (write),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .sel   (sel),
        .txd   (txd),
        .rxd   (rxd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus access; reads queue their expected byte and pop it when ready rises.
    task automatic applyStimulus(input string name, input logic wr, input logic [1:0] off,
                                 input logic [7:0] wd, input logic [7:0] expect_rd, input int hold);
        int n;
        if (!wr) exp_q.push_back(expect_rd);
        @(negedge clk);
        valid = 1'b1;
        write = wr;
        addr  = BASE + {14'd0, off};
        wdata = wd;
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checkOutput({name, "_ready_timeout"}, {7'd0, ready}, 8'h01);
            if (!wr) void'(exp_q.pop_front());
        end else if (!wr) begin
            checkOutput(name, rdata, exp_q.pop_front());
        end
        repeat (hold) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        checkOutput({name, "_ready_release"}, {7'd0, ready}, 8'h00);
    endtask

    task automatic sendRx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (4) @(negedge clk);
        end
        rxd = stop;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic checkUnselected(input logic [15:0] a);
        @(negedge clk);
        valid = 1'b1;
        write = 1'b0;
        addr  = a;
        repeat (4) @(negedge clk);
        checkOutput("unsel_sel", {7'd0, sel}, 8'h00);
        checkOutput("unsel_ready", {7'd0, ready}, 8'h00);
        valid = 1'b0;
    endtask

    initial begin
        logic [7:0] tx_byte;

        vecs[0]  = '{1'b0, REG_DATA, 8'h00, 8'h00};
        vecs[1]  = '{1'b0, REG_STAT, 8'h00, 8'h02};
        vecs[2]  = '{1'b0, REG_DIVL, 8'h00, 8'h0F};
        vecs[3]  = '{1'b0, REG_DIVH, 8'h00, 8'h00};
        vecs[4]  = '{1'b1, REG_DIVH, 8'h5C, 8'h00};
        vecs[5]  = '{1'b0, REG_DIVH, 8'h00, 8'h5C};
        vecs[6]  = '{1'b1, REG_DIVL, 8'h03, 8'h00};
        vecs[7]  = '{1'b1, REG_DIVH, 8'h00, 8'h00};
        vecs[8]  = '{1'b0, REG_DIVL, 8'h00, 8'h03};
        vecs[9]  = '{1'b1, REG_STAT, 8'hFF, 8'h00};
        vecs[10] = '{1'b0, REG_STAT, 8'h00, 8'h02};

        repeat (3) @(negedge clk);
        checkOutput("rst_txd", {7'd0, txd}, 8'h01);
        checkOutput("rst_ready", {7'd0, ready}, 8'h00);
        checkOutput("rst_rdata", rdata, 8'h00);
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].wr, vecs[i].off, vecs[i].wd, vecs[i].expect_rd, 0);

        checkUnselected(BASE - 16'd1);
        checkUnselected(BASE + 16'd4);
        addr = BASE + 16'd3;
        #1;
        checkOutput("sel_top", {7'd0, sel}, 8'h01);

        // TX of A5 at div=3: every bit spans 4 clocks, LSB first.
        tx_byte = 8'hA5;
        repeat (4) tx_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) repeat (4) tx_q.push_back(tx_byte[b]);
        repeat (4) tx_q.push_back(1'b1);
        tx_q.push_back(1'b1);
        applyStimulus("tx_a5", 1'b1, REG_DATA, tx_byte, 8'h00, 0);
        for (int i = 0; i < 41; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput($sformatf("txd_bit%0d", i), {7'd0, txd}, {7'd0, tx_q.pop_front()});
        end
        repeat (4) @(negedge clk);
        applyStimulus("tx_done_stat", 1'b0, REG_STAT, 8'h00, 8'h02, 0);

        // FIFO fill during the first frame, then overrun and its clear.
        for (int i = 1; i <= 5; i++)
            applyStimulus("fill", 1'b1, REG_DATA, 8'(i), 8'h00, 0);
        applyStimulus("full_stat", 1'b0, REG_STAT, 8'h00, 8'h11, 0);
        applyStimulus("push6", 1'b1, REG_DATA, 8'h06, 8'h00, 0);
        applyStimulus("ovr_stat", 1'b0, REG_STAT, 8'h00, 8'h19, 0);
        applyStimulus("ovr_clr", 1'b1, REG_STAT, 8'h08, 8'h00, 0);
        applyStimulus("ovr_clr_stat", 1'b0, REG_STAT, 8'h00, 8'h11, 0);
        repeat (250) @(negedge clk);
        applyStimulus("drain_stat", 1'b0, REG_STAT, 8'h00, 8'h02, 0);

        sendRx(8'h3C, 1'b1);
        applyStimulus("rx_stat", 1'b0, REG_STAT, 8'h00, 8'h06, 0);
        applyStimulus("rx_data", 1'b0, REG_DATA, 8'h00, 8'h3C, 0);
        applyStimulus("rx_read_stat", 1'b0, REG_STAT, 8'h00, 8'h02, 0);

        sendRx(8'h11, 1'b1);
        sendRx(8'h22, 1'b1);
        applyStimulus("rx2_stat", 1'b0, REG_STAT, 8'h00, 8'h0E, 0);
        applyStimulus("rx2_data", 1'b0, REG_DATA, 8'h00, 8'h11, 0);
        @(negedge clk);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        applyStimulus("glitch_stat", 1'b0, REG_STAT, 8'h00, 8'h0A, 0);
        applyStimulus("glitch_data", 1'b0, REG_DATA, 8'h00, 8'h00, 0);
        applyStimulus("rx_ovr_clr", 1'b1, REG_STAT, 8'h08, 8'h00, 0);

        sendRx(8'h55, 1'b1);
        sendRx(8'hC3, 1'b0);
        applyStimulus("ferr_stat", 1'b0, REG_STAT, 8'h00, 8'h26, 0);
        applyStimulus("ferr_data", 1'b0, REG_DATA, 8'h00, 8'h55, 0);
        applyStimulus("ferr_clr", 1'b1, REG_STAT, 8'h20, 8'h00, 0);
        applyStimulus("ferr_clr_stat", 1'b0, REG_STAT, 8'h00, 8'h02, 0);

        // Long valid hold must push once: FIFO empty again right after the pop.
        applyStimulus("hold_push", 1'b1, REG_DATA, 8'h5A, 8'h00, 3);
        applyStimulus("hold_stat", 1'b0, REG_STAT, 8'h00, 8'h12, 0);
        repeat (60) @(negedge clk);
        applyStimulus("hold_done_stat", 1'b0, REG_STAT, 8'h00, 8'h02, 0);

        applyStimulus("rst_tx", 1'b1, REG_DATA, 8'h00, 8'h00, 0);
        repeat (12) @(negedge clk);
        checkOutput("midframe_txd", {7'd0, txd}, 8'h00);
        rstb = 1'b0;
        #1;
        checkOutput("async_rst_txd", {7'd0, txd}, 8'h01);
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_rst_txd", {7'd0, txd}, 8'h01);
        applyStimulus("post_rst_stat", 1'b0, REG_STAT, 8'h00, 8'h02, 0);
        applyStimulus("post_rst_div", 1'b0, REG_DIVL, 8'h00, 8'h0F, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
